param_updown_counter: RTL and testbench
=======================================

Name: param_updown_counter

Overview:
Parametrised successor to the team's 4-bit synchronous down counter. Adds configurable width and reset value, up/down direction, parallel load, count enable, free-run (wrap) or one-shot mode, and a start/busy/done control FSM with a terminal-count pulse. Used as a general event counter or interval timer inside datapath and control blocks. Single clock domain.

Parameters:
WIDTH, 4, counter width in bits (>=2).
RESET_VAL, {WIDTH{1'b1}}, count value applied on reset (default all-ones, matching the earlier down counter).
AUTO_START, 1, 1: FSM leaves reset in RUN; 0: FSM leaves reset in IDLE.
PRESCALE_W, 8, prescaler reload width (used only with COUNTER_PRESCALE_EN).

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  count enable; step only when high
dir  in  1  0 = count down, 1 = count up
mode  in  1  0 = free-run with wrap, 1 = one-shot
load  in  1  parallel load strobe
load_val  in  WIDTH  value loaded when load=1
start  in  1  start request from IDLE or DONE
clr_done  in  1  clears sticky done
count  out  WIDTH  current count (registered)
tc  out  1  terminal-count pulse (registered, 1 cycle)
busy  out  1  high while FSM is in RUN
done  out  1  sticky one-shot completion flag

Behaviour:
- Reset (rst=0, async): count=RESET_VAL, tc=0, done=0, state=RUN if AUTO_START else IDLE; busy follows state.
- FSM states: IDLE, RUN, DONE. busy = (state==RUN).
- Terminal value: 0 when dir=0; 2^WIDTH-1 when dir=1. dir is sampled at each step.
- step = (state==RUN) && en && tick; tick=1 every cycle unless the prescaler is compiled in.
- Per-edge priority: load > start > step.
- load: count<=load_val; tc<=0. If in DONE: state->IDLE and done<=0. IDLE/RUN state unchanged. A step requested in the same cycle is dropped.
- start in IDLE or DONE: state->RUN, count unchanged, done<=0. start in RUN is ignored.
- step, mode=0: count<=count-1 (dir=0) or count+1 (dir=1), modulo 2^WIDTH, so max->0 / 0->max wraps. tc<=1 on the edge where the new count equals terminal, else 0. Stays in RUN.
- step, mode=1: as mode=0, but on the edge where the new count equals terminal: tc<=1, done<=1, state->DONE. count then holds the terminal value.
- step while count is already at terminal and mode=1 (e.g. loaded with terminal then started): count wraps by one step. Completion is detected on arrival at terminal only.
- tc is high for exactly one cycle per terminal arrival. It is 0 whenever no step occurs.
- clr_done: done<=0 (state unchanged). If clr_done coincides with a one-shot completion, the completion wins and done=1.
- en=0 or state!=RUN: count and state hold; tc=0.
- mode change takes effect on the next step. Changing to mode=0 while in DONE does not leave DONE; start is required.
- Reset asserted mid-operation: immediate return to reset values regardless of clk.
- Latency: count reflects a step, load or start one edge after the qualifying inputs.

Optional Feature:
COUNTER_PRESCALE_EN
- Defined: adds input port presc [PRESCALE_W-1:0] after en. An internal prescaler counts down from presc, and tick=1 when it reaches 0, after which it reloads presc. The prescaler advances only in RUN with en=1. It resets to presc on rst, load, and start. presc=0 gives tick every cycle.
- Undefined: no presc port, no prescaler logic, tick=1 constant.

Test Plan:
1. Defaults, release rst with en=1, dir=0, mode=0 -> count 15,14,...,0,15; tc=1 only in the cycle count=0; busy=1 throughout.
2. WIDTH=8, dir=1, mode=1, load 8'hFC, start, en=1 -> count FD,FE,FF; tc and done rise with FF; busy=0; count holds FF for 10 more cycles.
3. load=1 and start=1 with en=1 in the same cycle while in RUN -> count=load_val, no step that cycle, state stays RUN.
4. In DONE, pulse clr_done -> done=0, still DONE; then start -> RUN, count steps from FF wrapping to 00 (dir=1).
5. Assert rst asynchronously between clock edges mid-count -> count=RESET_VAL, tc=0, done=0 immediately; AUTO_START=0 build stays IDLE with count frozen until start.
6. COUNTER_PRESCALE_EN, presc=3, en=1 -> count decrements once every 4 cycles; load mid-interval restarts the 4-cycle spacing.

Source files
------------

// File: rtl/param_updown_counter.sv
// param_updown_counter: parametrised up/down event counter / interval timer.
// Free-run (wrap) or one-shot mode, parallel load, count enable, and an
// IDLE/RUN/DONE control FSM with a one-cycle terminal-count pulse.
// Optional prescaler compiled in with `define COUNTER_PRESCALE_EN
// (adds the presc input port after en).
module param_updown_counter #(
  parameter int               WIDTH      = 4,
  parameter logic [WIDTH-1:0] RESET_VAL  = {WIDTH{1'b1}},
  parameter bit               AUTO_START = 1'b1,
  parameter int               PRESCALE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
`ifdef COUNTER_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] presc,
`endif
  input  logic                  dir,
  input  logic                  mode,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  start,
  input  logic                  clr_done,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             done_q, done_d;
  logic             tick;
  logic             start_ok;
  logic             step;
  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] term;

  // start is only honoured outside RUN; in RUN it is silently ignored
  assign start_ok = start && (state_q != RUN);
  assign step     = (state_q == RUN) && en && tick;
  assign nxt      = dir ? (count_q + 1'b1) : (count_q - 1'b1);
  assign term     = dir ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

`ifdef COUNTER_PRESCALE_EN
  // Prescaler: pcnt_q counts down; parm_q means "next value comes from presc",
  // which lets reset/load/start reload from the live presc input while the
  // async reset value itself stays constant.
  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d, peff;
  logic                  parm_q, parm_d;

  // Prescaler next state: reload on load/start, advance only in RUN with en
  always_comb begin
    peff   = parm_q ? presc : pcnt_q;
    tick   = (peff == '0);
    pcnt_d = pcnt_q;
    parm_d = parm_q;
    if (load || start_ok) begin
      parm_d = 1'b1;
    end else if ((state_q == RUN) && en) begin
      if (tick) begin
        parm_d = 1'b1;
      end else begin
        pcnt_d = peff - 1'b1;
        parm_d = 1'b0;
      end
    end
  end

  // Prescaler registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q <= '0;
      parm_q <= 1'b1;
    end else begin
      pcnt_q <= pcnt_d;
      parm_q <= parm_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // Next-state: load > start > step; a completion overrides a same-cycle clr_done
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = done_q;
    tc_d    = 1'b0;
    if (clr_done) done_d = 1'b0;
    if (load) begin
      count_d = load_val;
      if (state_q == DONE) begin
        state_d = IDLE;
        done_d  = 1'b0;
      end
    end else if (start_ok) begin
      state_d = RUN;
      done_d  = 1'b0;
    end else if (step) begin
      count_d = nxt;
      if (nxt == term) begin
        tc_d = 1'b1;
        if (mode) begin
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= AUTO_START ? RUN : IDLE;
      count_q <= RESET_VAL;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign busy  = (state_q == RUN);
  assign done  = done_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// Directed bench for param_updown_counter: a default 4-bit auto-start instance
// (A) and an 8-bit instance that leaves reset in IDLE (B), sharing controls.
module tb_param_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, dir = 1'b0, mode = 1'b0, load = 1'b0, start = 1'b0, clr_done = 1'b0;
  logic [7:0] lv = 8'h00;
  logic [3:0] cntA;
  logic [7:0] cntB;
  logic       tcA, busyA, doneA, tcB, busyB, doneB;
`ifdef COUNTER_PRESCALE_EN
  logic [7:0] presc = 8'd0;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  param_updown_counter u_a (
    .clk(clk), .rst(rst), .en(en),
`ifdef COUNTER_PRESCALE_EN
    .presc(presc),
`endif
    .dir(dir), .mode(mode), .load(load), .load_val(lv[3:0]), .start(start),
    .clr_done(clr_done), .count(cntA), .tc(tcA), .busy(busyA), .done(doneA));

  param_updown_counter #(.WIDTH(8), .AUTO_START(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en),
`ifdef COUNTER_PRESCALE_EN
    .presc(presc),
`endif
    .dir(dir), .mode(mode), .load(load), .load_val(lv), .start(start),
    .clr_done(clr_done), .count(cntB), .tc(tcB), .busy(busyB), .done(doneB));

  typedef struct {
    logic en, dir, mode, load, start, clr;
    logic [7:0] lv;
    logic [7:0] cnt;
    logic tc, busy, done;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic chkB(input string nm, input logic [7:0] c, input logic t, input logic b, input logic d);
    chk({nm, " cnt"},  {24'd0, cntB}, {24'd0, c});
    chk({nm, " tc"},   {31'd0, tcB},   {31'd0, t});
    chk({nm, " busy"}, {31'd0, busyB}, {31'd0, b});
    chk({nm, " done"}, {31'd0, doneB}, {31'd0, d});
  endtask

  initial begin
    // --- vector table for instance B (8-bit, starts IDLE at FF) ---
    tbl.push_back('{1,1,1,0,0,0,8'h00, 8'hFF,0,0,0}); // IDLE: frozen
    tbl.push_back('{1,1,1,1,0,0,8'hFC, 8'hFC,0,0,0}); // load in IDLE
    tbl.push_back('{1,1,1,0,1,0,8'h00, 8'hFC,0,1,0}); // start: count unchanged
    tbl.push_back('{1,1,1,0,0,0,8'h00, 8'hFD,0,1,0});
    tbl.push_back('{1,1,1,0,0,0,8'h00, 8'hFE,0,1,0});
    tbl.push_back('{1,1,1,0,0,0,8'h00, 8'hFF,1,0,1}); // one-shot completion
    for (int h = 0; h < 10; h++)
      tbl.push_back('{1,1,1,0,0,0,8'h00, 8'hFF,0,0,1}); // holds in DONE
    tbl.push_back('{1,1,1,0,0,1,8'h00, 8'hFF,0,0,0}); // clr_done, still DONE
    tbl.push_back('{1,1,1,0,0,0,8'h00, 8'hFF,0,0,0});
    tbl.push_back('{1,1,1,0,1,0,8'h00, 8'hFF,0,1,0}); // restart from DONE
    tbl.push_back('{1,1,1,0,0,0,8'h00, 8'h00,0,1,0}); // wraps FF->00
    tbl.push_back('{1,1,1,0,0,0,8'h00, 8'h01,0,1,0});
    tbl.push_back('{1,1,1,1,1,0,8'h80, 8'h80,0,1,0}); // load+start in RUN
    tbl.push_back('{1,0,1,0,0,0,8'h00, 8'h7F,0,1,0}); // down step
    tbl.push_back('{1,1,0,1,0,0,8'hFE, 8'hFE,0,1,0});
    tbl.push_back('{1,1,0,0,0,0,8'h00, 8'hFF,1,1,0}); // free-run terminal
    tbl.push_back('{1,1,0,0,0,0,8'h00, 8'h00,0,1,0}); // wraps, stays RUN
    tbl.push_back('{0,1,0,0,0,0,8'h00, 8'h00,0,1,0}); // en=0 holds
    tbl.push_back('{1,0,1,1,0,0,8'h01, 8'h01,0,1,0});
    tbl.push_back('{1,0,1,0,0,0,8'h00, 8'h00,1,0,1}); // down one-shot done
    tbl.push_back('{1,0,1,0,1,0,8'h00, 8'h00,0,1,0}); // start at terminal
    tbl.push_back('{1,0,1,0,0,0,8'h00, 8'hFF,0,1,0}); // wraps, no completion
    tbl.push_back('{1,0,1,1,0,0,8'h01, 8'h01,0,1,0});
    tbl.push_back('{1,0,1,0,0,1,8'h00, 8'h00,1,0,1}); // completion beats clr
    tbl.push_back('{1,0,0,0,0,0,8'h00, 8'h00,0,0,1}); // mode=0 stays DONE
    tbl.push_back('{1,0,0,1,0,0,8'h05, 8'h05,0,0,0}); // load in DONE -> IDLE
    tbl.push_back('{1,0,0,0,0,0,8'h00, 8'h05,0,0,0});

    // --- reset state ---
    #2 rst = 1'b0;
    #1;
    chk("rst A cnt",  {28'd0, cntA}, 32'hF);
    chk("rst A tc",   {31'd0, tcA},  32'd0);
    chk("rst A busy", {31'd0, busyA}, 32'd1);
    chk("rst A done", {31'd0, doneA}, 32'd0);
    chkB("rst B", 8'hFF, 1'b0, 1'b0, 1'b0);
    tick_edge();
    tick_edge();
    chk("rst A hold", {28'd0, cntA}, 32'hF);

    // --- A: free-running down count with wrap ---
    en = 1'b1; dir = 1'b0; mode = 1'b0;
    rst = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick_edge();
      chk($sformatf("A down k%0d cnt", k), {28'd0, cntA}, (32'd15 - k) & 32'hF);
      chk($sformatf("A down k%0d tc", k), {31'd0, tcA}, (k == 15) ? 32'd1 : 32'd0);
      chk($sformatf("A down k%0d busy", k), {31'd0, busyA}, 32'd1);
    end

    // --- B: table-driven vectors ---
    foreach (tbl[i]) begin
      en = tbl[i].en; dir = tbl[i].dir; mode = tbl[i].mode;
      load = tbl[i].load; start = tbl[i].start; clr_done = tbl[i].clr; lv = tbl[i].lv;
      tick_edge();
      chkB($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].tc, tbl[i].busy, tbl[i].done);
    end
    load = 1'b0; start = 1'b0; clr_done = 1'b0; lv = 8'h00;

    // --- async reset mid-operation ---
    start = 1'b1;
    tick_edge();
    start = 1'b0; load = 1'b1; lv = 8'h01; dir = 1'b0; mode = 1'b0;
    tick_edge();
    load = 1'b0;
    tick_edge();
    chkB("pre-rst", 8'h00, 1'b1, 1'b1, 1'b0);
    #2 rst = 1'b0;
    #1;
    chkB("async rst", 8'hFF, 1'b0, 1'b0, 1'b0);
    chk("async rst A cnt", {28'd0, cntA}, 32'hF);
    chk("async rst A busy", {31'd0, busyA}, 32'd1);
    tick_edge();
    rst = 1'b1; en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick_edge();
      chkB($sformatf("idle frz%0d", k), 8'hFF, 1'b0, 1'b0, 1'b0);
    end
    start = 1'b1;
    tick_edge();
    chkB("post-rst start", 8'hFF, 1'b0, 1'b1, 1'b0);
    start = 1'b0;
    tick_edge();
    chkB("post-rst step", 8'hFE, 1'b0, 1'b1, 1'b0);

`ifdef COUNTER_PRESCALE_EN
    // --- prescaler: one step every presc+1 enabled cycles ---
    presc = 8'd3; en = 1'b1; dir = 1'b0; mode = 1'b0;
    #2 rst = 1'b0;
    tick_edge();
    rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick_edge();
      chk($sformatf("presc e%0d", e), {28'd0, cntA}, 32'd15 - (e / 4));
    end
    // prescaler sits at 1 here; load restarts the 4-cycle spacing
    load = 1'b1; lv = 8'h09;
    tick_edge();
    load = 1'b0;
    chk("presc load", {28'd0, cntA}, 32'd9);
    for (int e = 1; e <= 5; e++) begin
      tick_edge();
      chk($sformatf("presc after load e%0d", e), {28'd0, cntA}, (e < 4) ? 32'd9 : 32'd8);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Absolute time bound so the run can never hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1);
  end

endmodule
